// File: rtl/sw_alloc_if.sv
// Bundle of the five-port request / grant / output signals used by the switch allocator.
interface sw_alloc_if #(
    parameter int unsigned DATASIZE = 40
);
    localparam int unsigned NP = 5;
    localparam int unsigned DW = 4;

    logic [NP-1:0]          req_valid;
    logic [NP*DW-1:0]       req_dir;
    logic [NP*DATASIZE-1:0] req_data;
    logic [NP-1:0]          in_ack;
    logic [NP-1:0]          out_valid;
    logic [NP*DATASIZE-1:0] out_data;
    logic [NP-1:0]          out_ready;
    logic [NP-1:0]          dir_err;

    // Traffic side: routers' input buffers and downstream links
    modport master (
        output req_valid, req_dir, req_data, out_ready,
        input  in_ack, out_valid, out_data, dir_err
    );

    // Allocator side
    modport slave (
        input  req_valid, req_dir, req_data, out_ready,
        output in_ack, out_valid, out_data, dir_err
    );
endinterface

// File: rtl/sw_alloc.sv
// Five-port switch allocator: one IDLE/BUSY round-robin arbiter per output port (0=N,1=E,2=W,3=S,4=L).
module sw_alloc #(
    parameter int unsigned DATASIZE = 40
) (
    input logic        sa_clk,
    input logic        rst,
    sw_alloc_if.slave  bus
);
    localparam int unsigned NP = 5;
    localparam int unsigned DW = 4;
    localparam int unsigned PW = 3;
    localparam int unsigned BW = NP * DATASIZE;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q [NP];
    state_t          state_d [NP];
    logic [PW-1:0]   owner_q [NP];
    logic [PW-1:0]   owner_d [NP];
    logic [PW-1:0]   ptr_q   [NP];
    logic [PW-1:0]   ptr_d   [NP];

    logic [NP-1:0]   out_valid_c;
    logic [NP-1:0]   xfer_c;
    logic [NP-1:0]   in_ack_c;
    logic [NP-1:0]   dir_err_c;
    logic [BW-1:0]   out_data_c;
    logic [NP-1:0]   req_c [NP];
    logic            found;
    logic [PW-1:0]   idx;

    // Output datapath: granted flit, transfer detection, acks and illegal-direction flags
    always_comb begin
        out_valid_c = '0;
        out_data_c  = '0;
        xfer_c      = '0;
        in_ack_c    = '0;
        dir_err_c   = '0;
        for (int o = 0; o < NP; o++) begin
            if (!rst && state_q[o] == BUSY) begin
                out_valid_c[o] = 1'b1;
                out_data_c[DATASIZE*o +: DATASIZE] =
                    bus.req_data[DATASIZE*32'(owner_q[o]) +: DATASIZE];
                xfer_c[o] = bus.out_ready[o];
            end
        end
        for (int i = 0; i < NP; i++) begin
            for (int o = 0; o < NP; o++) begin
                if (xfer_c[o] && owner_q[o] == PW'(i)) begin
                    in_ack_c[i] = 1'b1;
                end
            end
            dir_err_c[i] = !rst && bus.req_valid[i] && (bus.req_dir[DW*i +: DW] >= DW'(NP));
        end
    end

    // Request matrix req_c[o][i]; an input being acked this cycle is not a new requester
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            req_c[o] = '0;
            for (int i = 0; i < NP; i++) begin
                req_c[o][i] = bus.req_valid[i] && !in_ack_c[i] &&
                              (bus.req_dir[DW*i +: DW] == DW'(o));
            end
        end
    end

    // Per-output next state: round-robin grant from ptr in IDLE, release on transfer in BUSY
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int o = 0; o < NP; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            found      = 1'b0;
            case (state_q[o])
                IDLE: begin
                    for (int unsigned k = 0; k < NP; k++) begin
                        idx = PW'((32'(ptr_q[o]) + k) % NP);
                        if (!found && req_c[o][idx]) begin
                            found      = 1'b1;
                            owner_d[o] = idx;
                            state_d[o] = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (xfer_c[o]) begin
                        state_d[o] = IDLE;
                        ptr_d[o]   = (owner_q[o] == PW'(NP - 1)) ? '0 : owner_q[o] + PW'(1);
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    // State, owner and pointer registers with synchronous reset
    always_ff @(posedge sa_clk) begin
        for (int o = 0; o < NP; o++) begin
            if (rst) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end else begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.in_ack    = in_ack_c;
    assign bus.dir_err   = dir_err_c;
endmodule

// File: tb/tb_sw_alloc.sv
// Self-checking bench for sw_alloc: directed vector table, reset-mid-transfer sequence, random traffic vs model.
module tb_sw_alloc;
    localparam int unsigned DS = 40;
    localparam int unsigned NP = 5;
    localparam int unsigned BW = NP * DS;
    localparam logic [DS-1:0] D4 = 40'h12_3456_789A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sw_alloc_if #(.DATASIZE(DS)) bus ();
    sw_alloc #(.DATASIZE(DS)) dut (.sa_clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit            m_busy [NP];
    int            m_own  [NP];
    int            m_rr   [NP];
    logic [NP-1:0] m_valid, m_ack, m_err;
    logic [BW-1:0] m_data;

    typedef struct {
        logic          r;
        logic [4:0]    v;
        logic [19:0]   d;
        logic [4:0]    rdy;
        logic [4:0]    ev;
        logic [4:0]    ea;
        logic [4:0]    ee;
        int            dchk_o;
        logic [DS-1:0] dchk_v;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [DS-1:0] dat(int i);
        return (i == 4) ? D4 : 40'hC0_DE00_0000 + DS'(i);
    endfunction

    function automatic logic [19:0] dirs(int d0, int d1, int d2, int d3, int d4);
        return {4'(d4), 4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    endfunction

    function automatic int dir_of(int i);
        return int'(32'(bus.req_dir[4*i +: 4]));
    endfunction

    task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(logic r, logic [4:0] v, logic [19:0] d, logic [4:0] rdy,
                       logic [4:0] ev, logic [4:0] ea, logic [4:0] ee,
                       int o = -1, logic [DS-1:0] dv = '0);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.rdy = rdy;
        t.ev = ev; t.ea = ea; t.ee = ee; t.dchk_o = o; t.dchk_v = dv;
        tbl.push_back(t);
    endtask

    // Expected outputs for the current cycle from the model's view of who owns each output
    task automatic model_outputs();
        m_valid = '0; m_ack = '0; m_err = '0; m_data = '0;
        for (int o = 0; o < NP; o++) begin
            if (m_busy[o] && !rst) begin
                m_valid[o] = 1'b1;
                m_data[o*DS +: DS] = bus.req_data[m_own[o]*DS +: DS];
                if (bus.out_ready[o]) m_ack[m_own[o]] = 1'b1;
            end
        end
        for (int i = 0; i < NP; i++)
            if (!rst && bus.req_valid[i] && dir_of(i) > 4) m_err[i] = 1'b1;
    endtask

    // Model update at the clock edge
    task automatic model_advance();
        for (int o = 0; o < NP; o++) begin
            if (rst) begin
                m_busy[o] = 0; m_own[o] = 0; m_rr[o] = 0;
            end else if (m_busy[o]) begin
                if (bus.out_ready[o]) begin
                    m_busy[o] = 0;
                    m_rr[o] = (m_own[o] + 1) % NP;
                end
            end else begin
                for (int k = 0; k < NP; k++) begin
                    int i;
                    i = (m_rr[o] + k) % NP;
                    if (bus.req_valid[i] && dir_of(i) == o && !m_ack[i]) begin
                        m_busy[o] = 1; m_own[o] = i;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic settle(string tag);
        #2;
        model_outputs();
        chk({tag, " model valid"}, BW'(bus.out_valid), BW'(m_valid));
        chk({tag, " model ack"},   BW'(bus.in_ack),    BW'(m_ack));
        chk({tag, " model err"},   BW'(bus.dir_err),   BW'(m_err));
        chk({tag, " model data"},  bus.out_data,       m_data);
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        #2;
    endtask

    task automatic set_in(logic [4:0] v, logic [19:0] d, logic [4:0] rdy);
        bus.req_valid = v;
        bus.req_dir   = d;
        bus.out_ready = rdy;
    endtask

    bit            act  [NP];
    logic [3:0]    adir [NP];
    logic [DS-1:0] adat [NP];
    logic [NP-1:0] last_ack;

    initial begin
        rst = 1'b1;
        set_in('0, '0, '0);
        for (int i = 0; i < NP; i++) begin
            bus.req_data[i*DS +: DS] = dat(i);
            m_busy[i] = 0; m_own[i] = 0; m_rr[i] = 0;
        end

        // Reset: outputs quiet even with illegal requests present
        add(1, 5'b11111, dirs(7,7,7,7,7), 5'b11111, 0, 0, 0, 0, '0);
        add(1, 5'b11111, dirs(7,7,7,7,7), 5'b11111, 0, 0, 0, 4, '0);
        // Single flit L -> E
        add(0, 5'b10000, dirs(0,0,0,0,1), 5'b11111, 5'b00000, 5'b00000, 0);
        add(0, 5'b10000, dirs(0,0,0,0,1), 5'b11111, 5'b00010, 5'b10000, 0, 1, D4);
        add(0, 5'b00000, dirs(0,0,0,0,1), 5'b11111, 5'b00000, 5'b00000, 0, 1, '0);
        // Fairness on output L: grants 0,2,3,0,2,3
        for (int r = 0; r < 6; r++) begin
            int own;
            own = (r % 3 == 0) ? 0 : (r % 3 == 1) ? 2 : 3;
            add(0, 5'b01101, dirs(4,0,4,4,0), 5'b11111, 0, 0, 0);
            add(0, 5'b01101, dirs(4,0,4,4,0), 5'b11111, 5'b10000, 5'(1 << own), 0, 4, dat(own));
        end
        add(0, 5'b00000, '0, 5'b11111, 0, 0, 0, 4, '0);
        // Illegal code on input 3
        for (int r = 0; r < 3; r++) add(0, 5'b01000, dirs(0,0,0,7,0), 5'b11111, 0, 0, 5'b01000);
        add(0, 5'b00000, '0, 5'b11111, 0, 0, 0);
        // Concurrency 0->2, 1->3, 2->0
        add(0, 5'b00111, dirs(2,3,0,0,0), 5'b11111, 0, 0, 0);
        add(0, 5'b00111, dirs(2,3,0,0,0), 5'b11111, 5'b01101, 5'b00111, 0, 2, dat(0));
        add(0, 5'b00000, '0, 5'b11111, 0, 0, 0);
        // Backpressure on output 3
        add(0, 5'b00010, dirs(0,3,0,0,0), 5'b10111, 0, 0, 0);
        for (int r = 0; r < 4; r++) add(0, 5'b00010, dirs(0,3,0,0,0), 5'b10111, 5'b01000, 0, 0, 3, dat(1));
        add(0, 5'b00010, dirs(0,3,0,0,0), 5'b11111, 5'b01000, 5'b00010, 0, 3, dat(1));
        add(0, 5'b00000, '0, 5'b11111, 0, 0, 0, 3, '0);

        @(posedge clk); #2;
        foreach (tbl[n]) begin
            string tag;
            tag = $sformatf("row%0d", n);
            rst = tbl[n].r;
            set_in(tbl[n].v, tbl[n].d, tbl[n].rdy);
            settle(tag);
            chk({tag, " out_valid"}, BW'(bus.out_valid), BW'(tbl[n].ev));
            chk({tag, " in_ack"},    BW'(bus.in_ack),    BW'(tbl[n].ea));
            chk({tag, " dir_err"},   BW'(bus.dir_err),   BW'(tbl[n].ee));
            if (tbl[n].dchk_o >= 0)
                chk({tag, " out_data slice"}, BW'(bus.out_data[tbl[n].dchk_o*DS +: DS]), BW'(tbl[n].dchk_v));
            advance();
        end

        // Reset mid-transfer: output 0 BUSY with owner 3 and ptr 3, then reset
        set_in(5'b00100, '0, 5'b11111);
        settle("rst_seq a");
        chk("rst_seq a valid", BW'(bus.out_valid), '0);
        advance();
        settle("rst_seq b");
        chk("rst_seq b valid", BW'(bus.out_valid), BW'(5'b00001));
        chk("rst_seq b ack",   BW'(bus.in_ack),    BW'(5'b00100));
        advance();
        set_in(5'b01010, '0, 5'b11110);
        settle("rst_seq c");
        advance();
        settle("rst_seq d");
        chk("rst_seq d valid", BW'(bus.out_valid), BW'(5'b00001));
        chk("rst_seq d ack",   BW'(bus.in_ack),    '0);
        chk("rst_seq d data",  BW'(bus.out_data[0 +: DS]), BW'(dat(3)));
        advance();
        rst = 1'b1;
        set_in(5'b01010, '0, 5'b11111);
        settle("rst_seq e");
        chk("rst_seq e valid", BW'(bus.out_valid), '0);
        chk("rst_seq e ack",   BW'(bus.in_ack),    '0);
        advance();
        rst = 1'b0;
        settle("rst_seq f");
        chk("rst_seq f valid", BW'(bus.out_valid), '0);
        advance();
        settle("rst_seq g");
        chk("rst_seq g valid", BW'(bus.out_valid), BW'(5'b00001));
        chk("rst_seq g ack",   BW'(bus.in_ack),    BW'(5'b00010));
        chk("rst_seq g data",  BW'(bus.out_data[0 +: DS]), BW'(dat(1)));
        advance();
        set_in('0, '0, 5'b11111);
        settle("rst_seq h");
        advance();

        // Random traffic against the model
        last_ack = '0;
        for (int i = 0; i < NP; i++) act[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (act[i] && last_ack[i]) act[i] = 0;
                if (act[i] && adir[i] > 4'd4 && $urandom_range(3) == 0) act[i] = 0;
                else if (!act[i] && $urandom_range(2) == 0) begin
                    act[i]  = 1;
                    adir[i] = ($urandom_range(9) == 0) ? 4'($urandom_range(15, 5)) : 4'($urandom_range(4));
                    adat[i] = {8'($urandom), $urandom};
                end
                bus.req_valid[i]         = act[i];
                bus.req_dir[4*i +: 4]    = act[i] ? adir[i] : 4'($urandom);
                bus.req_data[i*DS +: DS] = act[i] ? adat[i] : {8'($urandom), $urandom};
                bus.out_ready[i]         = ($urandom_range(9) < 7);
            end
            rst = ($urandom_range(199) == 0);
            settle($sformatf("rand%0d", c));
            last_ack = m_ack;
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sw_alloc.md
SW_ALLOC -- requirements
Module: sw_alloc

Interface
REQ-001 Parameter DATASIZE, default 40: flit width in bits.
REQ-002 Port numbering SHALL be 0=N, 1=E, 2=W, 3=S, 4=L for all 5-bit vectors and DATASIZE-wide slices.
REQ-003 sa_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  5  per-input-port request; held until in_ack.
REQ-006 req_dir  input  20  per-input 4-bit destination code, slice [4i+3:4i]; codes 0..4 are output ports, 5..15 are illegal.
REQ-007 req_data  input  5*DATASIZE  per-input flit, slice [DATASIZE*i +: DATASIZE].
REQ-008 in_ack  output  5  per-input transfer-complete pulse.
REQ-009 out_valid  output  5  per-output flit valid.
REQ-010 out_data  output  5*DATASIZE  per-output flit, same slicing as req_data.
REQ-011 out_ready  input  5  per-output downstream ready; a transfer occurs when out_valid[o] and out_ready[o] are both 1.
REQ-012 dir_err  output  5  per-input one-cycle pulse on an illegal req_dir.

Function
REQ-013 Each output o SHALL have an independent FSM with states IDLE and BUSY, a 3-bit owner register and a 3-bit round-robin pointer ptr (range 0..4).
REQ-014 Input i requests output o when req_valid[i]=1, req_dir slice i = o, and in_ack[i]=0 in that cycle.
REQ-015 IDLE with at least one requester: select the first requester scanning ptr, ptr+1, ... modulo 5; load owner; next state BUSY.
REQ-016 IDLE with no requester: remain IDLE; ptr unchanged.
REQ-017 BUSY: out_valid[o]=1 and out_data slice o = req_data slice owner, combinationally from the current inputs.
REQ-018 BUSY with a transfer: in_ack[owner]=1 in the same cycle; ptr <= (owner+1) mod 5; next state IDLE.
REQ-019 BUSY without out_ready: hold state, owner and ptr; out_valid stays 1 (no withdrawal).
REQ-020 Grant latency: out_valid SHALL rise exactly one cycle after the first cycle a request is seen in IDLE; minimum spacing between transfers on one output is 2 cycles.
REQ-021 Different outputs SHALL grant concurrently and independently; each input is owned by at most one output because it has a single req_dir.
REQ-022 in_ack[i] SHALL be 0 unless some output is BUSY with owner=i and transferring.
REQ-023 Illegal req_dir (5..15) with req_valid=1: no request is raised, dir_err[i]=1 each such cycle, and the input is never acked.
REQ-024 Requester contract: req_valid, req_dir and req_data stay stable from assertion until in_ack. Violations are undefined; the design SHALL NOT lock up.
REQ-025 out_data slice o SHALL be all-zero whenever out_valid[o]=0.

Reset
REQ-026 While rst=1 at a rising edge: all FSMs go IDLE, owner=0, ptr=0.
REQ-027 During reset, out_valid=0, in_ack=0, dir_err=0 and out_data=0.
REQ-028 Reset mid-transfer (BUSY) SHALL drop the grant with no in_ack; arbitration restarts from ptr=0 on the first cycle after rst deasserts.

Verification
REQ-029 Single flit: after reset, input 4 (L) sends dir=1 with data 0x12_3456_789A and out_ready[1]=1 -> out_valid[1]=1 on the next cycle with that data; in_ack[4]=1 in the same cycle; out_valid[1]=0 on the following cycle.
REQ-030 Fairness: inputs 0, 2 and 3 all hold dir=4 with out_ready[4]=1 continuously -> grant order 0, 2, 3, 0, 2, 3; one transfer every 2 cycles.
REQ-031 Backpressure: input 1 granted to output 3 with out_ready[3]=0 for 4 cycles -> out_valid[3] and out_data stay constant and in_ack[1]=0; when out_ready[3] goes to 1 -> in_ack[1]=1 that cycle.
REQ-032 Concurrency: inputs 0->2, 1->3 and 2->0 requested in the same cycle with all ready -> all three outputs valid on the next cycle; all three acks in that cycle.
REQ-033 Illegal code: input 3 sends dir=7 for 3 cycles -> dir_err[3]=1 for those 3 cycles, out_valid stays 0 on all outputs, and in_ack[3] stays 0.
REQ-034 Reset mid-operation: output 0 BUSY with owner=3 and ptr=3, then rst=1 for 1 cycle -> out_valid=0, no ack; inputs 1 and 3 still requesting output 0 -> input 1 is granted first (ptr=0).
